// File: rtl/operand_serializer_pkg.sv
// rtl/operand_serializer_pkg.sv - shared numerics and state encodings for operand_serializer
package operand_serializer_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // A one-cycle frame still needs a one-bit counter.
    function automatic int unsigned cnt_bits(input int unsigned frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/operand_serializer_piso_shift_reg.sv
// rtl/operand_serializer_piso_shift_reg.sv - parallel-load, right-shift, zero-fill operand register
module piso_shift_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             lsb_o
);

    logic [WIDTH-1:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (clear_i) begin
            sr_d = '0;
        end else if (shift_i) begin
            sr_d = sr_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign lsb_o = sr_q[0];

endmodule

// File: rtl/operand_serializer.sv
// rtl/operand_serializer.sv - frames a parallel operand as LSB-first bits followed by zero flush bits
module operand_serializer
    import operand_serializer_pkg::*;
#(
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned FLUSH_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned      FRAME_LEN  = WIDTH + FLUSH_CYCLES;
    localparam int unsigned      CNT_W      = cnt_bits(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             valid_q, valid_d;
    logic             first_q, first_d;
    logic             last_q, last_d;
    logic             accept;
    logic             sr_load, sr_shift, sr_clear;

    // The final frame cycle doubles as an acceptance slot for zero-bubble streaming.
    assign in_ready = (state_q == ST_IDLE) || last_q;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        first_d  = first_q;
        last_d   = last_q;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_clear = 1'b0;
        if (in_ready) begin
            if (accept) begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
                valid_d = 1'b1;
                first_d = 1'b1;
                last_d  = (FRAME_LEN == 1);
                sr_load = 1'b1;
            end else begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                valid_d  = 1'b0;
                first_d  = 1'b0;
                last_d   = 1'b0;
                sr_clear = 1'b1;
            end
        end else begin
            // Zero fill empties the register by the time FLUSH is reached.
            state_d  = (cnt_inc <= LAST_SHIFT) ? ST_SHIFT : ST_FLUSH;
            cnt_d    = cnt_inc;
            first_d  = 1'b0;
            last_d   = (cnt_inc == LAST_CNT);
            sr_shift = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_piso (
        .clk     (clk),
        .rst_ni  (rst),
        .load_i  (sr_load),
        .shift_i (sr_shift),
        .clear_i (sr_clear),
        .data_i  (in_data),
        .lsb_o   (ser_out)
    );

    assign ser_valid = valid_q;
    assign ser_first = first_q;
    assign ser_last  = last_q;
    assign busy      = valid_q;

endmodule
